vc_allocator: RTL and testbench

- Router-level virtual-channel allocator that shares the downstream VCs of every output port among all input-port VCs in the VA state.
- Per output port, it tracks which downstream VCs are free and round-robin arbitrates among the input VCs requesting that port.
- It returns a grant plus the downstream VC id to each input buffer. These drive each input buffer's vc_valid_i and vc_new_i.
- Frees a downstream VC when the downstream router signals that the VC has gone idle.

---
 rtl/vc_allocator_pkg.sv | 15 +
 rtl/vc_allocator_rr_arbiter.sv | 54 +++++
 rtl/vc_allocator.sv | 122 ++++++++++++
 tb/tb_vc_allocator.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_allocator_pkg.sv
// noc_params: router-wide parameters and types shared by the input buffer
// and the VC allocator.
//   PORT_NUM : number of input ports and number of output ports
//   VC_NUM   : virtual channels per port
//   VC_SIZE  : width of a VC id
//   port_t   : output port encoding
package noc_params;

    localparam int PORT_NUM = 5;
    localparam int VC_NUM   = 2;
    localparam int VC_SIZE  = $clog2(VC_NUM);

    typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;

endpackage

// File: rtl/vc_allocator_rr_arbiter.sv
// rr_arbiter: N-way round-robin arbiter with its own priority pointer.
//   clk, rst : clock, asynchronous active-high reset
//   req_i    : request vector
//   upd_i    : advance the pointer past the winner at the next edge
//              (only takes effect when some request is present)
//   gnt_o    : one-hot grant, combinational
//   idx_o    : index of the winner, combinational
// The winner is the first requester at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_i,
    input  logic          upd_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] hi_idx, lo_idx;
    logic          hi_vld, lo_vld;

    // Scanning downward leaves the lowest hits: lo_* is the lowest requester
    // overall (the wrap-around choice), hi_* the lowest at or above ptr_q.
    always_comb begin
        hi_idx = '0;
        lo_idx = '0;
        hi_vld = 1'b0;
        lo_vld = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req_i[j]) begin
                lo_idx = IW'(j);
                lo_vld = 1'b1;
                if (IW'(j) >= ptr_q) begin
                    hi_idx = IW'(j);
                    hi_vld = 1'b1;
                end
            end
        end
        idx_o = hi_vld ? hi_idx : lo_idx;
        gnt_o = lo_vld ? (N'(1) << idx_o) : '0;
        ptr_d = ptr_q;
        if (upd_i && lo_vld)
            ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + IW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/vc_allocator.sv
// vc_allocator: router VC allocator. Each output port owns VC_NUM downstream
// VCs; input VCs in the VA state request a port and one of them per port wins
// round-robin, receiving the lowest-numbered free downstream VC.
//   clk, rst             : clock, asynchronous active-high reset
//   request_i[p][v]      : VA request from input VC (p,v)
//   out_port_i[p][v]     : output port wanted by (p,v), valid with request
//   idle_downstream_vc_i : [o][d] pulse, downstream VC d behind port o is free
//   grant_o[p][v]        : (p,v) has been allocated a downstream VC
//   vc_new_o[p][v]       : allocated downstream VC id, valid with grant
// Build option VC_ALLOC_REG_OUT_EN: grant_o/vc_new_o come from registers
// (1-cycle latency) and an input VC with a grant showing is kept out of
// arbitration so it cannot be granted twice. Undefined: combinational grant.
module vc_allocator
    import noc_params::*;
(
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic  [PORT_NUM-1:0][VC_NUM-1:0]          request_i,
    input  port_t [PORT_NUM-1:0][VC_NUM-1:0]          out_port_i,
    input  logic  [PORT_NUM-1:0][VC_NUM-1:0]          idle_downstream_vc_i,
    output logic  [PORT_NUM-1:0][VC_NUM-1:0]          grant_o,
    output logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] vc_new_o
);

    localparam int N  = PORT_NUM * VC_NUM;
    localparam int IW = $clog2(N);

    logic [PORT_NUM-1:0][VC_NUM-1:0]              avail_q, avail_d, taken, mask, gnt_c;
    logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] vcn_c;
    logic [PORT_NUM-1:0][N-1:0]                   cand, arb_req, arb_gnt;
    logic [PORT_NUM-1:0][IW-1:0]                  arb_idx;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]             free_vc;
    logic [PORT_NUM-1:0]                          has_free;

    // Lowest-index free downstream VC per output port.
    always_comb begin
        free_vc  = '0;
        has_free = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            has_free[o] = |avail_q[o];
            for (int d = VC_NUM - 1; d >= 0; d--)
                if (avail_q[o][d]) free_vc[o] = VC_SIZE'(d);
        end
    end

    // Candidates per output port, flattened as p*VC_NUM+v.
    always_comb begin
        cand = '0;
        for (int o = 0; o < PORT_NUM; o++)
            for (int p = 0; p < PORT_NUM; p++)
                for (int v = 0; v < VC_NUM; v++)
                    cand[o][p*VC_NUM+v] = request_i[p][v] & ~mask[p][v] &
                                          (out_port_i[p][v] == port_t'(o));
    end

    // A port with no free VC presents no requests, so its pointer holds.
    for (genvar o = 0; o < PORT_NUM; o++) begin : g_port
        assign arb_req[o] = cand[o] & {N{has_free[o]}};
        rr_arbiter #(.N(N)) u_arb (
            .clk   (clk),
            .rst   (rst),
            .req_i (arb_req[o]),
            .upd_i (has_free[o]),
            .gnt_o (arb_gnt[o]),
            .idx_o (arb_idx[o])
        );
    end

    // Route each port's winner back to its input VC and mark the VC taken.
    always_comb begin
        gnt_c = '0;
        vcn_c = '0;
        taken = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            if (|arb_gnt[o]) begin
                taken[o][free_vc[o]] = 1'b1;
                for (int p = 0; p < PORT_NUM; p++)
                    for (int v = 0; v < VC_NUM; v++)
                        if (arb_idx[o] == IW'(p*VC_NUM+v)) begin
                            gnt_c[p][v] = 1'b1;
                            vcn_c[p][v] = free_vc[o];
                        end
            end
        end
    end

    // Grant picks from the pre-edge mask, so it never collides with a release.
    assign avail_d = (avail_q & ~taken) | idle_downstream_vc_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) avail_q <= '1;
        else     avail_q <= avail_d;
    end

`ifdef VC_ALLOC_REG_OUT_EN
    logic [PORT_NUM-1:0][VC_NUM-1:0]              grant_q;
    logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] vcn_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q <= '0;
            vcn_q   <= '0;
        end else begin
            grant_q <= gnt_c;
            vcn_q   <= vcn_c;
        end
    end

    assign mask     = grant_q;
    assign grant_o  = grant_q;
    assign vc_new_o = vcn_q;
`else
    assign mask     = '0;
    // Outputs are combinational, so hold them low while reset is asserted.
    assign grant_o  = rst ? '0 : gnt_c;
    assign vc_new_o = rst ? '0 : vcn_c;
`endif

    a_release_free : assert property (@(posedge clk) disable iff (rst)
        (idle_downstream_vc_i & avail_q) == '0);

endmodule

// File: tb/tb_vc_allocator.sv
module tb_vc_allocator;
    import noc_params::*;

    localparam int N = PORT_NUM * VC_NUM;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]              req, idle, grant;
    port_t [PORT_NUM-1:0][VC_NUM-1:0]              op;
    logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] vcn;

    always #5 clk = ~clk;

    vc_allocator dut (
        .clk                  (clk),
        .rst                  (rst),
        .request_i            (req),
        .out_port_i           (op),
        .idle_downstream_vc_i (idle),
        .grant_o              (grant),
        .vc_new_o             (vcn)
    );

    // Reference model: free flags and round-robin pointer per output port.
    bit m_avail[PORT_NUM][VC_NUM];
    int m_ptr[PORT_NUM];
    int win_k[PORT_NUM], win_d[PORT_NUM];
    bit exp_g[PORT_NUM][VC_NUM];
    int exp_v[PORT_NUM][VC_NUM];
    int checks = 0;
    int fails  = 0;

    function automatic void model_reset();
        for (int o = 0; o < PORT_NUM; o++) begin
            m_ptr[o] = 0;
            win_k[o] = -1;
            win_d[o] = -1;
            for (int d = 0; d < VC_NUM; d++) m_avail[o][d] = 1'b1;
        end
        for (int p = 0; p < PORT_NUM; p++)
            for (int v = 0; v < VC_NUM; v++) begin
                exp_g[p][v] = 1'b0;
                exp_v[p][v] = 0;
            end
    endfunction

    function automatic void model_eval();
        for (int p = 0; p < PORT_NUM; p++)
            for (int v = 0; v < VC_NUM; v++) begin
                exp_g[p][v] = 1'b0;
                exp_v[p][v] = 0;
            end
        for (int o = 0; o < PORT_NUM; o++) begin
            win_k[o] = -1;
            win_d[o] = -1;
            if (!rst) begin
                for (int d = 0; d < VC_NUM; d++)
                    if (m_avail[o][d] && win_d[o] < 0) win_d[o] = d;
                if (win_d[o] >= 0)
                    for (int i = 0; i < N; i++) begin
                        int k;
                        k = (m_ptr[o] + i) % N;
                        if (win_k[o] < 0 && req[k/VC_NUM][k%VC_NUM] &&
                            op[k/VC_NUM][k%VC_NUM] == port_t'(o))
                            win_k[o] = k;
                    end
                if (win_k[o] >= 0) begin
                    exp_g[win_k[o]/VC_NUM][win_k[o]%VC_NUM] = 1'b1;
                    exp_v[win_k[o]/VC_NUM][win_k[o]%VC_NUM] = win_d[o];
                end
            end
        end
    endfunction

    function automatic void model_commit();
        for (int o = 0; o < PORT_NUM; o++)
            if (win_k[o] >= 0) begin
                m_avail[o][win_d[o]] = 1'b0;
                m_ptr[o] = (win_k[o] + 1) % N;
            end
        for (int o = 0; o < PORT_NUM; o++)
            for (int d = 0; d < VC_NUM; d++)
                if (idle[o][d]) m_avail[o][d] = 1'b1;
    endfunction

    function automatic void compare();
        logic [PORT_NUM-1:0][VC_NUM-1:0] eg;
        for (int p = 0; p < PORT_NUM; p++)
            for (int v = 0; v < VC_NUM; v++) eg[p][v] = exp_g[p][v];
        checks++;
        if (grant !== eg) begin
            fails++;
            $display("FAIL grant_o t=%0t got=%b exp=%b", $time, grant, eg);
        end
        for (int p = 0; p < PORT_NUM; p++)
            for (int v = 0; v < VC_NUM; v++)
                if (exp_g[p][v]) begin
                    checks++;
                    if (vcn[p][v] !== VC_SIZE'(exp_v[p][v])) begin
                        fails++;
                        $display("FAIL vc_new_o[%0d][%0d] t=%0t got=%0d exp=%0d",
                                 p, v, $time, vcn[p][v], exp_v[p][v]);
                    end
                end
        if (rst) begin
            checks++;
            if (vcn !== '0) begin
                fails++;
                $display("FAIL vc_new_o_reset t=%0t got=%b exp=0", $time, vcn);
            end
        end
    endfunction

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s t=%0t got=%0d exp=%0d", nm, $time, act, exp);
        end
    endfunction

    // Cycle protocol: inputs change at negedge, outputs checked 1 ns later,
    // model state advances at the posedge, release pulses last one cycle.
    task automatic settle();
        #1;
        model_eval();
        compare();
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_commit();
        @(negedge clk);
        idle = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        model_eval();
        compare();
        @(posedge clk);
        @(negedge clk);
        idle = '0;
        rst  = 1'b0;
    endtask

    int rr_k[4] = '{0, 5, 8, 0};

    initial begin
        req  = '0;
        idle = '0;
        for (int p = 0; p < PORT_NUM; p++)
            for (int v = 0; v < VC_NUM; v++) op[p][v] = LOCAL;
        model_reset();
        @(negedge clk);
        do_reset();

        // Reset state
        settle();
        chk("rst_grant", int'(grant), 0);
        chk("rst_vcnew", int'(vcn), 0);
        tick();

        // Two back-to-back grants per port get VC 0 then VC 1
        for (int o = 0; o < PORT_NUM; o++) begin
            req = '0; req[1][0] = 1'b1; op[1][0] = port_t'(o);
            settle();
            chk("seq_gnt_a", int'(grant[1][0]), 1);
            chk("seq_vc_a", int'(vcn[1][0]), 0);
            tick();
            req = '0; req[0][1] = 1'b1; op[0][1] = port_t'(o);
            settle();
            chk("seq_gnt_b", int'(grant[0][1]), 1);
            chk("seq_vc_b", int'(vcn[0][1]), 1);
            tick();
            req = '0; idle[o] = '1;
            settle();
            tick();
        end

        // Round-robin on NORTH with persistent requesters
        do_reset();
        req = '0;
        req[0][0] = 1'b1; op[0][0] = NORTH;
        req[2][1] = 1'b1; op[2][1] = NORTH;
        req[4][0] = 1'b1; op[4][0] = NORTH;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) idle[NORTH][(c-1)%2] = 1'b1;
            settle();
            chk("rr_order", int'(grant), 1 << rr_k[c]);
            chk("rr_vc", int'(vcn[rr_k[c]/VC_NUM][rr_k[c]%VC_NUM]), c % 2);
            tick();
        end
        req = '0; idle[NORTH][1] = 1'b1;
        settle();
        tick();

        // Exhaustion of SOUTH and release
        do_reset();
        req = '0;
        req[0][0] = 1'b1; op[0][0] = SOUTH;
        req[1][0] = 1'b1; op[1][0] = SOUTH;
        req[2][0] = 1'b1; op[2][0] = SOUTH;
        settle();
        chk("exh_g1", int'(grant), 1 << 0);
        chk("exh_v1", int'(vcn[0][0]), 0);
        tick();
        req[0][0] = 1'b0;
        settle();
        chk("exh_g2", int'(grant), 1 << 2);
        chk("exh_v2", int'(vcn[1][0]), 1);
        tick();
        req[1][0] = 1'b0;
        settle();
        chk("exh_stall", int'(grant), 0);
        tick();
        idle[SOUTH][1] = 1'b1;
        settle();
        chk("exh_rel_same_cycle", int'(grant), 0);
        tick();
        settle();
        chk("exh_rel_gnt", int'(grant[2][0]), 1);
        chk("exh_rel_vc", int'(vcn[2][0]), 1);
        tick();
        req = '0;

        // Independent ports in the same cycle
        do_reset();
        req[0][0] = 1'b1; op[0][0] = WEST;
        req[3][1] = 1'b1; op[3][1] = LOCAL;
        settle();
        chk("par_gnt", int'(grant), (1 << 0) | (1 << 7));
        chk("par_vc_w", int'(vcn[0][0]), 0);
        chk("par_vc_l", int'(vcn[3][1]), 0);
        tick();
        req = '0;

        // Reset with every VC allocated
        do_reset();
        for (int p = 0; p < PORT_NUM; p++) begin
            req[p][0] = 1'b1; op[p][0] = port_t'(p);
        end
        settle();
        chk("fill_a", int'(grant), 'h155);
        tick();
        req = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            req[p][1] = 1'b1; op[p][1] = port_t'(p);
        end
        settle();
        chk("fill_b", int'(grant), 'h2AA);
        tick();
        req = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            req[p][0] = 1'b1; op[p][0] = port_t'(p);
        end
        settle();
        chk("full_stall", int'(grant), 0);
        rst = 1'b1;
        #1;
        model_reset();
        model_eval();
        compare();
        chk("rst_async_grant", int'(grant), 0);
        @(posedge clk);
        @(negedge clk);
        idle = '0;
        rst  = 1'b0;
        settle();
        chk("post_rst_gnt", int'(grant), 'h155);
        chk("post_rst_vc", int'(vcn[4][0]), 0);
        tick();
        req = '0;

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                req = '0;
                do_reset();
            end
            for (int p = 0; p < PORT_NUM; p++)
                for (int v = 0; v < VC_NUM; v++) begin
                    if (exp_g[p][v])
                        req[p][v] = 1'b0;
                    else if (req[p][v]) begin
                        if ($urandom_range(15) == 0) req[p][v] = 1'b0;
                    end else if ($urandom_range(2) == 0) begin
                        req[p][v] = 1'b1;
                        op[p][v]  = port_t'($urandom_range(PORT_NUM - 1));
                    end
                    if (!req[p][v]) op[p][v] = port_t'($urandom_range(PORT_NUM - 1));
                end
            for (int o = 0; o < PORT_NUM; o++)
                for (int d = 0; d < VC_NUM; d++)
                    idle[o][d] = (!m_avail[o][d] && $urandom_range(3) == 0);
            settle();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
